multicycle_control: RTL and testbench
=====================================

// Module: multicycle_control
// PURPOSE
//  Main control FSM of the multicycle MIPS datapath. Sits directly upstream of the
//  ALU control decoder: decodes the instruction opcode and sequences fetch/decode/
//  execute/memory/writeback. Drives the datapath strobes and the 3-bit ALU-op code
//  (alu_op, fed to the decoder's cnrl input). Handshakes with memory via mem_ready.
// PARAMETERS
//  MEM_TIMEOUT  15  cycles a memory state waits for mem_ready before abort (1..255)
// PORTS
//  clk           in   1  system clock, rising edge
//  rst_n         in   1  asynchronous active-low reset
//  opcode        in   6  instr[31:26] from instruction register
//  zero          in   1  ALU zero flag
//  mem_ready     in   1  memory completes current read/write this cycle
//  pc_write      out  1  PC load enable (branch condition already applied)
//  iord          out  1  0: mem addr = PC, 1: mem addr = ALUOut
//  mem_read      out  1  memory read request
//  mem_write     out  1  memory write request
//  ir_write      out  1  instruction register load
//  reg_dst       out  1  1: rd, 0: rt
//  mem_to_reg    out  1  1: MDR, 0: ALUOut to register file
//  reg_write     out  1  register file write enable
//  alu_src_a     out  1  0: PC, 1: A
//  alu_src_b     out  2  00 B, 01 const 4, 10 imm, 11 imm<<2
//  ext_zero      out  1  1: zero-extend immediate, 0: sign-extend
//  pc_source     out  2  00 ALU, 01 ALUOut, 10 jump target
//  alu_op        out  3  000 add,001 sub,010 funct,011 slt,100 and,101 or,110 xor
//  illegal_op    out  1  one-cycle pulse: unknown opcode seen in DECODE
//  bus_error     out  1  one-cycle pulse: memory timeout abort
//  state         out  4  current state (debug)
// BEHAVIOUR
//  - rst_n=0: state=FETCH(0), wait counter=0, op latch=0, illegal_op=bus_error=0;
//    all strobes (pc_write,mem_*,ir_write,reg_write) forced 0 while rst_n=0.
//  - Reset mid-instruction: abort immediately; first cycle after release is FETCH.
//  - Outputs combinational from state (+mem_ready/zero where noted); unlisted = 0.
//  - FETCH(0): mem_read, src_b=01, op=000; ir_write=pc_write=mem_ready; stay until
//    mem_ready -> DECODE.
//  - DECODE(1): src_b=11, op=000; opcode latched into op register here; next by
//    opcode: 000000 EXEC_R; 100011/101011 MEM_ADDR; 000100/000101 BRANCH;
//    000010 JUMP; 001000/001010/001100/001101/001110 EXEC_I; other -> FETCH,
//    illegal_op pulses in the cycle after DECODE (registered).
//  - MEM_ADDR(2): src_a=1, src_b=10, op=000 -> MEM_READ(lw) or MEM_WRITE(sw).
//  - MEM_READ(3): mem_read, iord=1; mem_ready -> WB_MEM.
//  - WB_MEM(4): reg_write, mem_to_reg=1, reg_dst=0 -> FETCH.
//  - MEM_WRITE(5): mem_write, iord=1; mem_ready -> FETCH.
//  - EXEC_R(6): src_a=1, src_b=00, op=010 -> WB_R(7): reg_write, reg_dst=1.
//  - BRANCH(8): src_a=1, src_b=00, op=001, pc_source=01;
//    pc_write = zero (beq) / ~zero (bne) -> FETCH.
//  - JUMP(9): pc_source=10, pc_write=1 -> FETCH.
//  - EXEC_I(10): src_a=1, src_b=10; op: addi 000, slti 011, andi 100, ori 101,
//    xori 110; ext_zero=1 for andi/ori/xori -> WB_I(11): reg_write, reg_dst=0.
//  - Wait counter (8b): cleared on entry to FETCH/MEM_READ/MEM_WRITE, +1 per cycle
//    with mem_ready=0. On reaching MEM_TIMEOUT (mem_ready still 0): -> FETCH,
//    bus_error pulses next cycle, no pc_write/ir_write/reg_write for that access.
//    mem_ready=1 in the same cycle the count hits MEM_TIMEOUT: normal completion wins.
//  - Codes 12-15 unreachable; if entered -> FETCH next cycle, all strobes 0.
//  - CPI: R/addi-class 4, lw 5, sw 4, beq/bne/j 3 (mem_ready=1 every cycle).
// TESTING
//  - Reset: rst_n=0 mid-EXEC_R -> state=0, strobes 0 asynchronously; release ->
//    FETCH with mem_read=1.
//  - lw (100011), mem_ready=1: states 0,1,2,3,4,0; reg_write=1 and mem_to_reg=1
//    only in state 4.
//  - beq zero=1 -> pc_write=1, pc_source=01 in state 8; bne zero=1 -> pc_write=0.
//  - andi (001100): state 10 gives alu_op=100, ext_zero=1; then state 11 reg_write.
//  - opcode 111111 in DECODE -> next state 0, illegal_op=1 for exactly 1 cycle.
//  - sw, mem_ready held 0, MEM_TIMEOUT=15: 15 cycles in state 5 then FETCH,
//    bus_error 1 cycle; repeat with mem_ready=1 on cycle 15 -> no bus_error.

Source files
------------

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle MIPS datapath.
// Decodes the opcode and sequences fetch/decode/execute/memory/writeback, driving the
// datapath strobes and the 3-bit ALU-op code consumed by the ALU control decoder.
// Memory states wait on mem_ready with a bounded wait counter.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   opcode                instr[31:26] from the instruction register
//   zero                  ALU zero flag (branch condition)
//   mem_ready             memory completes the current access this cycle
//   pc_write .. pc_source datapath control strobes/selects
//   alu_op                000 add, 001 sub, 010 funct, 011 slt, 100 and, 101 or, 110 xor
//   illegal_op            one-cycle pulse after DECODE saw an unknown opcode
//   bus_error             one-cycle pulse after a memory timeout abort
//   state                 current state (debug)
module multicycle_control #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       ext_zero,
    output logic [1:0] pc_source,
    output logic [2:0] alu_op,
    output logic       illegal_op,
    output logic       bus_error,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StMemAddr  = 4'd2,
        StMemRead  = 4'd3,
        StWbMem    = 4'd4,
        StMemWrite = 4'd5,
        StExecR    = 4'd6,
        StWbR      = 4'd7,
        StBranch   = 4'd8,
        StJump     = 4'd9,
        StExecI    = 4'd10,
        StWbI      = 4'd11
    } state_e;

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpBne   = 6'b000101;
    localparam logic [5:0] OpJ     = 6'b000010;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpSlti  = 6'b001010;
    localparam logic [5:0] OpAndi  = 6'b001100;
    localparam logic [5:0] OpOri   = 6'b001101;
    localparam logic [5:0] OpXori  = 6'b001110;

    // Timeout fires when the count would reach MEM_TIMEOUT with mem_ready still low.
    localparam logic [7:0] WaitLast = 8'(MEM_TIMEOUT - 1);

    state_e     state_q, state_d;
    logic [7:0] wait_q, wait_d;
    logic [5:0] op_q;
    logic       illegal_q, illegal_d;
    logic       bus_err_q;
    logic       in_mem_state;
    logic       timeout;

    assign in_mem_state = (state_q == StFetch) || (state_q == StMemRead) ||
                          (state_q == StMemWrite);
    assign timeout      = in_mem_state && !mem_ready && (wait_q == WaitLast);

    assign state      = state_q;
    assign illegal_op = illegal_q;
    assign bus_error  = bus_err_q;

    // Next state
    always_comb begin
        state_d   = StFetch;
        illegal_d = 1'b0;
        unique case (state_q)
            StFetch: begin
                if (mem_ready) state_d = StDecode;
                else           state_d = StFetch;
            end
            StDecode: begin
                unique case (opcode)
                    OpRtype:                                state_d = StExecR;
                    OpLw, OpSw:                             state_d = StMemAddr;
                    OpBeq, OpBne:                           state_d = StBranch;
                    OpJ:                                    state_d = StJump;
                    OpAddi, OpSlti, OpAndi, OpOri, OpXori:  state_d = StExecI;
                    default: begin
                        state_d   = StFetch;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            StMemAddr:  state_d = (op_q == OpLw) ? StMemRead : StMemWrite;
            StMemRead: begin
                if (mem_ready)    state_d = StWbMem;
                else if (timeout) state_d = StFetch;
                else              state_d = StMemRead;
            end
            StMemWrite: begin
                if (mem_ready || timeout) state_d = StFetch;
                else                      state_d = StMemWrite;
            end
            StExecR:  state_d = StWbR;
            StExecI:  state_d = StWbI;
            default:  state_d = StFetch;  // writebacks, branch, jump, unused codes
        endcase
    end

    // Wait counter: restarts on every state change and after a FETCH timeout retry.
    always_comb begin
        wait_d = wait_q;
        if ((state_d != state_q) || timeout) begin
            wait_d = 8'd0;
        end else if (in_mem_state && !mem_ready) begin
            wait_d = wait_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StFetch;
            wait_q    <= 8'd0;
            op_q      <= 6'd0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            illegal_q <= illegal_d;
            bus_err_q <= timeout;
            if (state_q == StDecode) op_q <= opcode;
        end
    end

    // Outputs
    always_comb begin
        pc_write   = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        ext_zero   = 1'b0;
        pc_source  = 2'b00;
        alu_op     = 3'b000;
        unique case (state_q)
            StFetch: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            StDecode:  alu_src_b = 2'b11;
            StMemAddr: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            StMemRead: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            StWbMem: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            StMemWrite: begin
                mem_write = 1'b1;
                iord      = 1'b1;
            end
            StExecR: begin
                alu_src_a = 1'b1;
                alu_op    = 3'b010;
            end
            StWbR: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            StBranch: begin
                alu_src_a = 1'b1;
                alu_op    = 3'b001;
                pc_source = 2'b01;
                pc_write  = (op_q == OpBeq) ? zero : ~zero;
            end
            StJump: begin
                pc_source = 2'b10;
                pc_write  = 1'b1;
            end
            StExecI: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                unique case (op_q)
                    OpSlti:  alu_op = 3'b011;
                    OpAndi:  alu_op = 3'b100;
                    OpOri:   alu_op = 3'b101;
                    OpXori:  alu_op = 3'b110;
                    default: alu_op = 3'b000;
                endcase
                ext_zero = (op_q == OpAndi) || (op_q == OpOri) || (op_q == OpXori);
            end
            StWbI:   reg_write = 1'b1;
            default: ;
        endcase
        // Strobes must be quiet while reset is held, even though FETCH is the reset state.
        if (!rst_n) begin
            pc_write  = 1'b0;
            mem_read  = 1'b0;
            mem_write = 1'b0;
            ir_write  = 1'b0;
            reg_write = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: an instruction-level model emits the expected
// per-cycle control word into a queue; a negedge monitor pops and compares.
module tb_multicycle_control;

    localparam int unsigned TO = 15;

    localparam logic [5:0] OpR = 6'b000000, OpLw = 6'b100011, OpSw = 6'b101011;
    localparam logic [5:0] OpBeq = 6'b000100, OpBne = 6'b000101, OpJ = 6'b000010;
    localparam logic [5:0] OpAddi = 6'b001000, OpSlti = 6'b001010, OpAndi = 6'b001100;
    localparam logic [5:0] OpOri = 6'b001101, OpXori = 6'b001110;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opcode = 6'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       pc_write, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg;
    logic       reg_write, alu_src_a, ext_zero, illegal_op, bus_error;
    logic [1:0] alu_src_b, pc_source;
    logic [2:0] alu_op;
    logic [3:0] state;

    multicycle_control #(.MEM_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .ext_zero(ext_zero), .pc_source(pc_source), .alu_op(alu_op),
        .illegal_op(illegal_op), .bus_error(bus_error), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] st;
        logic       pc_write, iord, mem_read, mem_write, ir_write;
        logic       reg_dst, mem_to_reg, reg_write, alu_src_a;
        logic [1:0] alu_src_b;
        logic       ext_zero;
        logic [1:0] pc_source;
        logic [2:0] alu_op;
        logic       illegal_op, bus_error;
    } exp_t;

    exp_t q[$];
    exp_t mon_e, mon_a;
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   pend_ill = 1'b0;
    bit   pend_bus = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", name, act, exp);
        end
    endtask

    // Monitor
    initial forever begin
        @(negedge clk);
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            mon_a = {state, pc_write, iord, mem_read, mem_write, ir_write, reg_dst,
                     mem_to_reg, reg_write, alu_src_a, alu_src_b, ext_zero, pc_source,
                     alu_op, illegal_op, bus_error};
            n_tests++;
            if (mon_a !== mon_e) begin
                n_fail++;
                $display("FAIL cycle t=%0t got=%h exp=%h (state got %0d exp %0d)",
                         $time, mon_a, mon_e, mon_a.st, mon_e.st);
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog");
    end

    function automatic exp_t at(input logic [3:0] st);
        exp_t e = '0;
        e.st = st;
        return e;
    endfunction

    function automatic bit is_legal(input logic [5:0] op);
        return op inside {OpR, OpLw, OpSw, OpBeq, OpBne, OpJ, OpAddi, OpSlti, OpAndi,
                          OpOri, OpXori};
    endfunction

    function automatic logic [2:0] imm_alu(input logic [5:0] op);
        case (op)
            OpSlti:  return 3'b011;
            OpAndi:  return 3'b100;
            OpOri:   return 3'b101;
            OpXori:  return 3'b110;
            default: return 3'b000;
        endcase
    endfunction

    // One cycle: registered pulses owed from the previous cycle land here.
    task automatic emit(input exp_t e, input logic mr, input logic [5:0] op, input logic z);
        e.illegal_op = pend_ill;
        e.bus_error  = pend_bus;
        pend_ill = 1'b0;
        pend_bus = 1'b0;
        q.push_back(e);
        mem_ready = mr;
        opcode    = op;
        zero      = z;
        @(posedge clk);
        #1;
    endtask

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    // A memory access stalled for 'waits' cycles; waits >= TO means it times out.
    task automatic access(input logic [3:0] st, input int waits, output bit ok);
        exp_t e = at(st);
        if (st == 4'd0) begin
            e.mem_read  = 1'b1;
            e.alu_src_b = 2'b01;
        end else if (st == 4'd3) begin
            e.mem_read = 1'b1;
            e.iord     = 1'b1;
        end else begin
            e.mem_write = 1'b1;
            e.iord      = 1'b1;
        end
        if (waits >= int'(TO)) begin
            for (int i = 0; i < int'(TO); i++) emit(e, 1'b0, 6'($urandom), rb());
            pend_bus = 1'b1;
            ok = 1'b0;
        end else begin
            for (int i = 0; i < waits; i++) emit(e, 1'b0, 6'($urandom), rb());
            if (st == 4'd0) begin
                e.ir_write = 1'b1;
                e.pc_write = 1'b1;
            end
            emit(e, 1'b1, 6'($urandom), rb());
            ok = 1'b1;
        end
    endtask

    task automatic fetch_decode(input logic [5:0] op, input int w_fetch);
        exp_t e;
        bit   ok;
        int   w = w_fetch;
        do begin
            access(4'd0, w, ok);
            w = 0;
        end while (!ok);
        e = at(4'd1);
        e.alu_src_b = 2'b11;
        emit(e, rb(), op, rb());
    endtask

    task automatic run_instr(input logic [5:0] op, input logic z, input int w_fetch,
                             input int w_mem);
        exp_t e;
        bit   ok;
        fetch_decode(op, w_fetch);
        if (op == OpR) begin
            e = at(4'd6); e.alu_src_a = 1'b1; e.alu_op = 3'b010;
            emit(e, rb(), 6'($urandom), rb());
            e = at(4'd7); e.reg_write = 1'b1; e.reg_dst = 1'b1;
            emit(e, rb(), 6'($urandom), rb());
        end else if (op == OpLw || op == OpSw) begin
            e = at(4'd2); e.alu_src_a = 1'b1; e.alu_src_b = 2'b10;
            emit(e, rb(), 6'($urandom), rb());
            access((op == OpLw) ? 4'd3 : 4'd5, w_mem, ok);
            if (op == OpLw && ok) begin
                e = at(4'd4); e.reg_write = 1'b1; e.mem_to_reg = 1'b1;
                emit(e, rb(), 6'($urandom), rb());
            end
        end else if (op == OpBeq || op == OpBne) begin
            e = at(4'd8); e.alu_src_a = 1'b1; e.alu_op = 3'b001; e.pc_source = 2'b01;
            e.pc_write = (op == OpBeq) ? z : ~z;
            emit(e, rb(), 6'($urandom), z);
        end else if (op == OpJ) begin
            e = at(4'd9); e.pc_source = 2'b10; e.pc_write = 1'b1;
            emit(e, rb(), 6'($urandom), rb());
        end else if (is_legal(op)) begin
            e = at(4'd10); e.alu_src_a = 1'b1; e.alu_src_b = 2'b10;
            e.alu_op = imm_alu(op);
            e.ext_zero = (op == OpAndi || op == OpOri || op == OpXori);
            emit(e, rb(), 6'($urandom), rb());
            e = at(4'd11); e.reg_write = 1'b1;
            emit(e, rb(), 6'($urandom), rb());
        end else begin
            pend_ill = 1'b1;
        end
    endtask

    function automatic int pick_waits();
        int r = int'($urandom_range(0, 19));
        if (r < 14)  return 0;
        if (r == 14) return 1;
        if (r == 15) return 2;
        if (r == 16) return 5;
        if (r == 17) return int'(TO) - 1;
        return int'(TO);
    endfunction

    logic [5:0] legal_ops [11] = '{OpR, OpLw, OpSw, OpBeq, OpBne, OpJ, OpAddi, OpSlti,
                                   OpAndi, OpOri, OpXori};

    initial begin
        logic [5:0] op;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_strobes", 32'({pc_write, mem_read, mem_write, ir_write, reg_write}), 32'd0);
        chk("rst_pulses", 32'({illegal_op, bus_error}), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_mem_read", 32'(mem_read), 32'd1);

        // Directed cases
        run_instr(OpLw, 1'b0, 0, 0);
        run_instr(OpBeq, 1'b1, 0, 0);
        run_instr(OpBne, 1'b1, 0, 0);
        run_instr(OpAndi, 1'b0, 0, 0);
        run_instr(6'b111111, 1'b0, 0, 0);
        run_instr(OpSw, 1'b0, 0, int'(TO));
        run_instr(OpSw, 1'b0, 0, int'(TO) - 1);
        run_instr(OpLw, 1'b0, 0, int'(TO));
        run_instr(OpJ, 1'b0, int'(TO), 0);
        run_instr(OpR, 1'b0, 0, 0);

        // Reset in the middle of EXEC_R
        fetch_decode(OpR, 0);
        chk("pre_rst_exec_r", 32'(state), 32'd6);
        rst_n = 1'b0;
        #1;
        chk("async_rst_state", 32'(state), 32'd0);
        chk("async_rst_strobes",
            32'({pc_write, mem_read, mem_write, ir_write, reg_write}), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        pend_ill = 1'b0;
        pend_bus = 1'b0;
        #1;
        chk("release_fetch", 32'({state, mem_read}), 32'h01);

        // Randomized traffic
        repeat (200) begin
            if ($urandom_range(0, 9) == 0) begin
                do op = 6'($urandom); while (is_legal(op));
            end else begin
                op = legal_ops[$urandom_range(0, 10)];
            end
            run_instr(op, rb(), pick_waits(), pick_waits());
        end

        @(negedge clk);
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
